// File: rtl/mailbox_ctrl.sv
// -----------------------------------------------------------------------------
// mailbox_ctrl
//   Single-slot mailbox controller. A producer writes one word into the
//   mailbox register and raises an external shared_flag (flag_set pulse).
//   The consumer side sees the flag come back on flag_value, offers the word
//   with a valid/ready handshake, then lowers the flag (flag_clear pulse).
//
// Ports
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   wr_req       producer send request, held until wr_ack
//   wr_data      producer word, sampled on the accept edge
//   wr_ack       one-cycle pulse: word accepted
//   flag_set     one-cycle pulse to shared_flag set input
//   flag_clear   one-cycle pulse to shared_flag clear input
//   flag_value   registered value returned by shared_flag
//   rd_valid     word offered to consumer
//   rd_data      offered word, stable while rd_valid
//   rd_ready     consumer accepts
//   timeout_err  sticky consumer-stall error
//
// Build option
//   MAILBOX_TIMEOUT_EN : when defined, a word left unaccepted for TIMEOUT_CYC
//   cycles is dropped and timeout_err is raised. When undefined, no counter
//   is built and timeout_err is tied low.
// -----------------------------------------------------------------------------
module mailbox_ctrl #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              flag_set,
    output logic              flag_clear,
    input  logic              flag_value,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              timeout_err
);

    localparam logic [0:0] P_IDLE  = 1'b0;
    localparam logic [0:0] P_BUSY  = 1'b1;

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_OFFER = 2'd1;
    localparam logic [1:0] C_CLEAR = 2'd2;

    logic [0:0]        r_p_state;
    logic [1:0]        r_c_state;
    logic [DATA_W-1:0] r_mailbox;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_wr_ack;
    logic              r_flag_set;
    logic              r_flag_clear;
    logic              r_rd_valid;

    logic              w_accept;
    logic              w_handshake;
    logic              w_expire;

    // Accept only when the previous message is fully retired: flag low and
    // the consumer back in C_IDLE (a consumer still in C_CLEAR blocks it).
    assign w_accept    = (r_p_state == P_IDLE) && wr_req && !flag_value &&
                         (r_c_state == C_IDLE);
    assign w_handshake = (r_c_state == C_OFFER) && r_rd_valid && rd_ready;

`ifdef MAILBOX_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout_err;

    // rd_ready on the expiry edge takes precedence as a normal handshake.
    assign w_expire = (r_c_state == C_OFFER) && !rd_ready &&
                      (r_stall_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_c_state == C_IDLE) && flag_value) begin
                r_stall_cnt <= '0;
            end else if ((r_c_state == C_OFFER) && !rd_ready && !w_expire) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYC >= 2);
    assign w_expire     = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // Producer side
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_p_state  <= P_IDLE;
            r_mailbox  <= '0;
            r_wr_ack   <= 1'b0;
            r_flag_set <= 1'b0;
        end else begin
            r_wr_ack   <= 1'b0;
            r_flag_set <= 1'b0;
            if (r_p_state == P_IDLE) begin
                if (w_accept) begin
                    r_mailbox  <= wr_data;
                    r_wr_ack   <= 1'b1;
                    r_flag_set <= 1'b1;
                    r_p_state  <= P_BUSY;
                end
            end else begin
                // Flag observed high: the message is now owned by the consumer.
                if (flag_value) begin
                    r_p_state <= P_IDLE;
                end
            end
        end
    end

    // Consumer side
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_c_state    <= C_IDLE;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_flag_clear <= 1'b0;
        end else begin
            r_flag_clear <= 1'b0;
            case (r_c_state)
                C_IDLE: begin
                    if (flag_value) begin
                        r_rd_data  <= r_mailbox;
                        r_rd_valid <= 1'b1;
                        r_c_state  <= C_OFFER;
                    end
                end
                C_OFFER: begin
                    if (w_handshake || w_expire) begin
                        r_rd_valid   <= 1'b0;
                        r_flag_clear <= 1'b1;
                        r_c_state    <= C_CLEAR;
                    end
                end
                C_CLEAR: begin
                    // Wait for the flag to drop so the same message is not
                    // consumed twice.
                    if (!flag_value) begin
                        r_c_state <= C_IDLE;
                    end
                end
                default: begin
                    r_c_state <= C_IDLE;
                end
            endcase
        end
    end

    assign wr_ack     = r_wr_ack;
    assign flag_set   = r_flag_set;
    assign flag_clear = r_flag_clear;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;

endmodule
